// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, ALU codes, class and state encodings for the control sequencer
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_ALU3,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

endpackage

// File: rtl/cpu_control_seq_if.sv
// rtl/cpu_control_seq_if.sv - sequencer inputs, datapath strobes and status bundle
interface cpu_control_seq_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
);
    logic              run;
    logic              mem_ready;
    logic [DATA_W-1:0] ir;

    logic pc_out, mar_in, inc_pc, pc_in;
    logic mdr_read, mdr_in, mdr_out, ir_in;
    logic y_in, zlo_in, zhigh_in, zlo_out, zhigh_out;
    logic lo_in, hi_in;

    logic [NREGS-1:0] reg_in;
    logic [NREGS-1:0] reg_out;
    logic [3:0]       alu_op;

    logic busy, done, illegal, halted;

    modport master (
        input  run, mem_ready, ir,
        output pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in, mdr_out, ir_in,
               y_in, zlo_in, zhigh_in, zlo_out, zhigh_out, lo_in, hi_in,
               reg_in, reg_out, alu_op, busy, done, illegal, halted
    );

    modport slave (
        output run, mem_ready, ir,
        input  pc_out, mar_in, inc_pc, pc_in, mdr_read, mdr_in, mdr_out, ir_in,
               y_in, zlo_in, zhigh_in, zlo_out, zhigh_out, lo_in, hi_in,
               reg_in, reg_out, alu_op, busy, done, illegal, halted
    );
endinterface

// File: rtl/cpu_opdecode.sv
// rtl/cpu_opdecode.sv - combinational opcode to {class, alu_op, legal}
module cpu_opdecode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [3:0] alu_op,
    output logic       legal
);
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALU_NONE;
        case (opcode)
            OP_ADD:  begin op_class = CLS_ALU3;   alu_op = ALU_ADD; end
            OP_SUB:  begin op_class = CLS_ALU3;   alu_op = ALU_SUB; end
            OP_AND:  begin op_class = CLS_ALU3;   alu_op = ALU_AND; end
            OP_OR:   begin op_class = CLS_ALU3;   alu_op = ALU_OR;  end
            OP_SHR:  begin op_class = CLS_ALU3;   alu_op = ALU_SHR; end
            OP_SHL:  begin op_class = CLS_ALU3;   alu_op = ALU_SHL; end
            OP_ROR:  begin op_class = CLS_ALU3;   alu_op = ALU_ROR; end
            OP_ROL:  begin op_class = CLS_ALU3;   alu_op = ALU_ROL; end
            OP_MUL:  begin op_class = CLS_MULDIV; alu_op = ALU_MUL; end
            OP_DIV:  begin op_class = CLS_MULDIV; alu_op = ALU_DIV; end
            OP_NOP:  op_class = CLS_NOP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILLEGAL;
        endcase
        legal = (op_class != CLS_ILLEGAL);
    end
endmodule

// File: rtl/cpu_control_seq.sv
// rtl/cpu_control_seq.sv - multi-cycle fetch/decode/execute control sequencer
module cpu_control_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 16,
    parameter int MEM_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    cpu_control_seq_if.master  bus
);
    localparam int REG_IDX_W = $clog2(NREGS);

    state_t    state, state_nxt;
    logic      first_t1;
    op_class_t op_class;
    logic [3:0] dec_alu_op;
    logic       dec_legal;

    logic [4:0]           opcode;
    logic [REG_IDX_W-1:0] ra, rb, rc;
    logic                 regs_ok;
    logic                 unused_ir_bits;

    assign opcode = bus.ir[DATA_W-1 -: 5];
    assign ra     = bus.ir[DATA_W-6 -: REG_IDX_W];
    assign rb     = bus.ir[DATA_W-6-REG_IDX_W -: REG_IDX_W];
    assign rc     = bus.ir[DATA_W-6-2*REG_IDX_W -: REG_IDX_W];
    assign unused_ir_bits = ^{bus.ir, dec_legal};

    cpu_opdecode u_opdecode (
        .opcode   (opcode),
        .op_class (op_class),
        .alu_op   (dec_alu_op),
        .legal    (dec_legal)
    );

    function automatic logic [NREGS-1:0] onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[i] = (idx == REG_IDX_W'(i));
        end
        return v;
    endfunction

    // MUL/DIV never write a general register, so ra is only range-checked for three-operand ops
    always_comb begin
        regs_ok = (32'(rb) < NREGS) && (32'(rc) < NREGS);
        if (op_class == CLS_ALU3) begin
            regs_ok = regs_ok && (32'(ra) < NREGS);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            first_t1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            first_t1 <= (state == S_T0);
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.pc_out    = 1'b0;
        bus.mar_in    = 1'b0;
        bus.inc_pc    = 1'b0;
        bus.pc_in     = 1'b0;
        bus.mdr_read  = 1'b0;
        bus.mdr_in    = 1'b0;
        bus.mdr_out   = 1'b0;
        bus.ir_in     = 1'b0;
        bus.y_in      = 1'b0;
        bus.zlo_in    = 1'b0;
        bus.zhigh_in  = 1'b0;
        bus.zlo_out   = 1'b0;
        bus.zhigh_out = 1'b0;
        bus.lo_in     = 1'b0;
        bus.hi_in     = 1'b0;
        bus.reg_in    = '0;
        bus.reg_out   = '0;
        bus.alu_op    = ALU_NONE;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.illegal   = 1'b0;
        bus.halted    = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.run) state_nxt = S_T0;
            end
            S_T0: begin
                bus.busy   = 1'b1;
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.zlo_in = 1'b1;
                state_nxt  = S_T1;
            end
            S_T1: begin
                bus.busy     = 1'b1;
                bus.mdr_read = 1'b1;
                bus.mdr_in   = 1'b1;
                bus.zlo_out  = first_t1;
                bus.pc_in    = first_t1;
                if (!(MEM_WAIT != 0 && !bus.mem_ready)) state_nxt = S_T2;
            end
            S_T2: begin
                bus.busy    = 1'b1;
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
                state_nxt   = S_T3;
            end
            S_T3: begin
                bus.busy = 1'b1;
                case (op_class)
                    CLS_ALU3, CLS_MULDIV: begin
                        if (regs_ok) begin
                            bus.reg_out = onehot(rb);
                            bus.y_in    = 1'b1;
                            state_nxt   = S_T4;
                        end else begin
                            bus.illegal = 1'b1;
                            bus.done    = 1'b1;
                            state_nxt   = bus.run ? S_T0 : S_IDLE;
                        end
                    end
                    CLS_NOP: begin
                        bus.done  = 1'b1;
                        state_nxt = bus.run ? S_T0 : S_IDLE;
                    end
                    CLS_HALT: state_nxt = S_HALT;
                    default: begin
                        bus.illegal = 1'b1;
                        bus.done    = 1'b1;
                        state_nxt   = bus.run ? S_T0 : S_IDLE;
                    end
                endcase
            end
            S_T4: begin
                bus.busy     = 1'b1;
                bus.reg_out  = onehot(rc);
                bus.zlo_in   = 1'b1;
                bus.zhigh_in = 1'b1;
                bus.alu_op   = dec_alu_op;
                state_nxt    = S_T5;
            end
            S_T5: begin
                bus.busy    = 1'b1;
                bus.zlo_out = 1'b1;
                if (op_class == CLS_MULDIV) begin
                    bus.lo_in = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    bus.reg_in = onehot(ra);
                    bus.done   = 1'b1;
                    state_nxt  = bus.run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                bus.busy      = 1'b1;
                bus.zhigh_out = 1'b1;
                bus.hi_in     = 1'b1;
                bus.done      = 1'b1;
                state_nxt     = bus.run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_control_seq.sv
// tb/tb_cpu_control_seq.sv - table-driven bench for cpu_control_seq
module tb_cpu_control_seq;
    import cpu_pkg::*;

    localparam logic [14:0] PC_OUT    = 15'h4000;
    localparam logic [14:0] MAR_IN    = 15'h2000;
    localparam logic [14:0] INC_PC    = 15'h1000;
    localparam logic [14:0] PC_IN     = 15'h0800;
    localparam logic [14:0] MDR_READ  = 15'h0400;
    localparam logic [14:0] MDR_IN    = 15'h0200;
    localparam logic [14:0] MDR_OUT   = 15'h0100;
    localparam logic [14:0] IR_IN     = 15'h0080;
    localparam logic [14:0] Y_IN      = 15'h0040;
    localparam logic [14:0] ZLO_IN    = 15'h0020;
    localparam logic [14:0] ZHIGH_IN  = 15'h0010;
    localparam logic [14:0] ZLO_OUT   = 15'h0008;
    localparam logic [14:0] ZHIGH_OUT = 15'h0004;
    localparam logic [14:0] LO_IN     = 15'h0002;
    localparam logic [14:0] HI_IN     = 15'h0001;
    localparam logic [14:0] NONE      = 15'h0000;

    localparam logic [3:0] ST_BUSY = 4'b1000;
    localparam logic [3:0] ST_DONE = 4'b0100;
    localparam logic [3:0] ST_ILL  = 4'b0010;
    localparam logic [3:0] ST_HLT  = 4'b0001;

    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_MUL  = 32'h70120000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    localparam logic [14:0] T0_STB = PC_OUT | MAR_IN | INC_PC | ZLO_IN;
    localparam logic [14:0] T1F    = ZLO_OUT | PC_IN | MDR_READ | MDR_IN;
    localparam logic [14:0] T1S    = MDR_READ | MDR_IN;
    localparam logic [14:0] T2_STB = MDR_OUT | IR_IN;

    typedef struct {
        logic        rst;
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [14:0] stb;
        logic [3:0]  st;
        logic [3:0]  alu;
        logic [15:0] rin;
        logic [15:0] rout;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    vec_t vq[$];

    cpu_control_seq_if #(.DATA_W(32), .NREGS(16)) bus ();

    cpu_control_seq #(.DATA_W(32), .NREGS(16), .MEM_WAIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic run, logic mr, logic [31:0] ir,
                                logic [14:0] stb, logic [3:0] st, logic [3:0] alu,
                                logic [15:0] rin, logic [15:0] rout);
        vec_t v;
        v.rst = rst; v.run = run; v.mr = mr; v.ir = ir;
        v.stb = stb; v.st = st; v.alu = alu; v.rin = rin; v.rout = rout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic [14:0] stb, input logic [3:0] st,
                               input logic [3:0] alu, input logic [15:0] rin, input logic [15:0] rout);
        logic [14:0] a_stb;
        logic [3:0]  a_st;
        a_stb = {bus.pc_out, bus.mar_in, bus.inc_pc, bus.pc_in, bus.mdr_read, bus.mdr_in,
                 bus.mdr_out, bus.ir_in, bus.y_in, bus.zlo_in, bus.zhigh_in, bus.zlo_out,
                 bus.zhigh_out, bus.lo_in, bus.hi_in};
        a_st  = {bus.busy, bus.done, bus.illegal, bus.halted};
        chk({tag, " strobes"}, 32'(a_stb), 32'(stb));
        chk({tag, " status"},  32'(a_st),  32'(st));
        chk({tag, " alu_op"},  32'(bus.alu_op), 32'(alu));
        chk({tag, " reg_in"},  32'(bus.reg_in), 32'(rin));
        chk({tag, " reg_out"}, 32'(bus.reg_out), 32'(rout));
    endtask

    initial begin
        // two reset cycles with run high, then ADD; MUL with a 3-cycle memory stall and run low
        vq.push_back(mk(0, 1, 1, IR_ADD, NONE, 4'b0, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, NONE, 4'b0, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, T0_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, T1F, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, T2_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, Y_IN, ST_BUSY, ALU_NONE, 16'h0, 16'h0004));
        vq.push_back(mk(1, 1, 1, IR_ADD, ZLO_IN | ZHIGH_IN, ST_BUSY, ALU_ADD, 16'h0, 16'h0008));
        vq.push_back(mk(1, 1, 1, IR_ADD, ZLO_OUT, ST_BUSY | ST_DONE, ALU_NONE, 16'h0002, 16'h0));
        vq.push_back(mk(1, 0, 1, IR_MUL, T0_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 0, 0, IR_MUL, T1F, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 0, 0, IR_MUL, T1S, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 0, 0, IR_MUL, T1S, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 0, 1, IR_MUL, T1S, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 0, 1, IR_MUL, T2_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 0, 1, IR_MUL, Y_IN, ST_BUSY, ALU_NONE, 16'h0, 16'h0004));
        vq.push_back(mk(1, 0, 1, IR_MUL, ZLO_IN | ZHIGH_IN, ST_BUSY, ALU_MUL, 16'h0, 16'h0010));
        vq.push_back(mk(1, 0, 1, IR_MUL, ZLO_OUT | LO_IN, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 0, 1, IR_MUL, ZHIGH_OUT | HI_IN, ST_BUSY | ST_DONE, ALU_NONE, 16'h0, 16'h0));
        // illegal opcode, then ADD interrupted by reset in T4
        vq.push_back(mk(1, 1, 1, IR_BAD, NONE, 4'b0, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_BAD, T0_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_BAD, T1F, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_BAD, T2_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_BAD, NONE, ST_BUSY | ST_DONE | ST_ILL, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, T0_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, T1F, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, T2_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0));
        vq.push_back(mk(1, 1, 1, IR_ADD, Y_IN, ST_BUSY, ALU_NONE, 16'h0, 16'h0004));
        vq.push_back(mk(0, 1, 1, IR_ADD, ZLO_IN | ZHIGH_IN, ST_BUSY, ALU_ADD, 16'h0, 16'h0008));
        vq.push_back(mk(1, 0, 1, IR_ADD, NONE, 4'b0, ALU_NONE, 16'h0, 16'h0));

        reset = 1'b0;
        bus.run = 1'b1;
        bus.mem_ready = 1'b1;
        bus.ir = IR_ADD;
        @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset = vq[i].rst;
            bus.run = vq[i].run;
            bus.mem_ready = vq[i].mr;
            bus.ir = vq[i].ir;
            #1;
            check_cycle($sformatf("row%0d", i), vq[i].stb, vq[i].st, vq[i].alu, vq[i].rin, vq[i].rout);
            @(posedge clk);
        end

        // HALT: fetch, decode without done, then parked despite run until reset
        @(negedge clk);
        reset = 1'b1;
        bus.run = 1'b1;
        bus.ir = IR_HALT;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("halt_fetch%0d busy", c), 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        check_cycle("halt_t3", NONE, ST_BUSY, ALU_NONE, 16'h0, 16'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_cycle($sformatf("halted%0d", c), NONE, ST_HLT, ALU_NONE, 16'h0, 16'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        check_cycle("halt_reset", NONE, 4'b0, ALU_NONE, 16'h0, 16'h0);
        reset = 1'b1;
        @(negedge clk);
        check_cycle("after_halt_t0", T0_STB, ST_BUSY, ALU_NONE, 16'h0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
